// File: rtl/min_int16_stream_pkg.sv
// Shared types and defaults for the streaming signed-minimum block.
package min_int16_stream_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/min_int16_stream_if.sv
// Input/output stream handshake bundle for min_int16_stream.
// out_idx exists only when MIN_INT16_STREAM_IDX_EN is defined.
interface min_int16_stream_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_min;
`ifdef MIN_INT16_STREAM_IDX_EN
    logic        [IDX_W-1:0] out_idx;
`endif

    if (IDX_W < 1) begin : g_bad_idx_w
        $error("IDX_W must be at least 1");
    end

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min
`ifdef MIN_INT16_STREAM_IDX_EN
        , input out_idx
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min
`ifdef MIN_INT16_STREAM_IDX_EN
        , output out_idx
`endif
    );

endinterface

// File: rtl/min_int16_stream_lt_int_nbit.sv
// Signed A < B comparator; IMPL_TYPE 0 uses the native signed compare,
// any other value splits on the sign bits and compares magnitudes unsigned.
module lt_int_nbit #(
    parameter int WIDTH     = 16,
    parameter int IMPL_TYPE = 1
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Y
);

    if (IMPL_TYPE == 0) begin : g_native
        assign Y = $signed(A) < $signed(B);
    end else begin : g_sign_split
        // Differing signs: A is smaller exactly when A is the negative one.
        // Same sign: two's-complement order matches unsigned order.
        assign Y = (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : (A < B);
    end

endmodule

// File: rtl/min_int16_stream.sv
// Frame-wise signed minimum over a valid/ready stream, result held until taken.
// Define MIN_INT16_STREAM_IDX_EN to also track and report the minimum's position.
module min_int16_stream
    import min_int16_stream_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int IMPL_TYPE = 1,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    min_int16_stream_if.slave  bus
);

    state_t                  state_reg, state_next;
    logic signed [WIDTH-1:0] min_reg, min_next;
    logic                    lt;
    logic                    accept;

`ifdef MIN_INT16_STREAM_IDX_EN
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
`endif

    if (IDX_W < 1) begin : g_bad_idx_w
        $error("IDX_W must be at least 1");
    end

    lt_int_nbit #(
        .WIDTH     (WIDTH),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_lt (
        .A (bus.in_data),
        .B (min_reg),
        .Y (lt)
    );

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            min_reg   <= '0;
`ifdef MIN_INT16_STREAM_IDX_EN
            idx_reg   <= '0;
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            min_reg   <= min_next;
`ifdef MIN_INT16_STREAM_IDX_EN
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
`ifdef MIN_INT16_STREAM_IDX_EN
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    min_next   = bus.in_data;
`ifdef MIN_INT16_STREAM_IDX_EN
                    idx_next   = '0;
                    cnt_next   = IDX_W'(1);
`endif
                    state_next = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Strict compare: ties keep the earlier element.
                    if (lt) begin
                        min_next = bus.in_data;
`ifdef MIN_INT16_STREAM_IDX_EN
                        idx_next = cnt_reg;
`endif
                    end
`ifdef MIN_INT16_STREAM_IDX_EN
                    cnt_next   = cnt_reg + IDX_W'(1);
`endif
                    state_next = bus.in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg != HOLD);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_min   = min_reg;
`ifdef MIN_INT16_STREAM_IDX_EN
    assign bus.out_idx   = idx_reg;
`endif

endmodule

// File: tb/tb_min_int16_stream.sv
// Directed checks of min_int16_stream: reset, framing, ties, backpressure, wrap, abort.
module tb_min_int16_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    min_int16_stream_if #(.WIDTH(16), .IDX_W(8)) bus ();

    min_int16_stream #(
        .WIDTH     (16),
        .IMPL_TYPE (1),
        .IDX_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drives one beat, waiting (bounded) for in_ready; returns #1 after the accepting edge.
    task automatic beat(input logic signed [15:0] d, input logic l);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL beat_ready_timeout in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic show(input string name, input int exp_min, input int exp_idx);
`ifdef MIN_INT16_STREAM_IDX_EN
        $display("frame %s: valid=%b min=%0d idx=%0d (expect min=%0d idx=%0d)",
                 name, bus.out_valid, bus.out_min, bus.out_idx, exp_min, exp_idx);
`else
        $display("frame %s: valid=%b min=%0d (expect min=%0d, idx %0d not built)",
                 name, bus.out_valid, bus.out_min, exp_min, exp_idx);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_min !== 16'sd0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in valid=%b min=%0d ready=%b required 0/0/1",
                     bus.out_valid, bus.out_min, bus.in_ready);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd0) begin
            failures++;
            $display("FAIL reset_idx idx=%0d required 0", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_min !== 16'sd0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_after valid=%b min=%0d ready=%b required 0/0/1",
                     bus.out_valid, bus.out_min, bus.in_ready);
        end
        $display("reset: valid=%b min=%0d ready=%b", bus.out_valid, bus.out_min, bus.in_ready);
    endtask

    task automatic test_basic_frame();
        beat(16'sd5, 1'b0);
        beat(-16'sd3, 1'b0);
        beat(16'sd7, 1'b0);
        beat(-16'sd3, 1'b1);
        show("basic", -3, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== -16'sd3) begin
            failures++;
            $display("FAIL basic_min valid=%b min=%0d required 1/-3", bus.out_valid, bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd1) begin
            failures++;
            $display("FAIL basic_idx idx=%0d required 1", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_release valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_single_beat();
        beat(-16'sd32768, 1'b1);
        show("single", -32768, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== -16'sd32768) begin
            failures++;
            $display("FAIL single_min valid=%b min=%0d required 1/-32768", bus.out_valid, bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd0) begin
            failures++;
            $display("FAIL single_idx idx=%0d required 0", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        beat(16'sd0, 1'b0);
        beat(16'sd32767, 1'b0);
        beat(-16'sd1, 1'b1);
        // A beat offered during HOLD must be refused and leave the result alone.
        bus.in_valid = 1'b1;
        bus.in_data  = -16'sd100;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_min !== -16'sd1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b min=%0d ready=%b required 1/-1/0",
                         i, bus.out_valid, bus.out_min, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        show("backpressure", -1, 2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release valid=%b ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_sign_order();
        beat(16'sd0, 1'b0);
        beat(-16'sd1, 1'b1);
        show("zero_then_neg1", -1, 1);
        checks++;
        if (bus.out_min !== -16'sd1) begin
            failures++;
            $display("FAIL sign_neg1_lt_0 min=%0d required -1", bus.out_min);
        end
        @(posedge clk);
        #1;
        beat(-16'sd1, 1'b0);
        beat(16'sd0, 1'b0);
        beat(16'sd32767, 1'b1);
        show("neg1_then_pos", -1, 0);
        checks++;
        if (bus.out_min !== -16'sd1) begin
            failures++;
            $display("FAIL sign_pos_not_lt min=%0d required -1", bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd0) begin
            failures++;
            $display("FAIL sign_pos_idx idx=%0d required 0", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        beat(16'sd10, 1'b0);
        bus.in_data = -16'sd999;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_min !== 16'sd10) begin
            failures++;
            $display("FAIL stall_idle valid=%b ready=%b min=%0d required 0/1/10",
                     bus.out_valid, bus.in_ready, bus.out_min);
        end
        beat(16'sd8, 1'b0);
        beat(16'sd12, 1'b1);
        show("stall", 8, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== 16'sd8) begin
            failures++;
            $display("FAIL stall_min valid=%b min=%0d required 1/8", bus.out_valid, bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd1) begin
            failures++;
            $display("FAIL stall_idx idx=%0d required 1", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_long_wrap();
        logic signed [15:0] v;
        for (int i = 0; i < 300; i++) begin
            if (i == 270 || i == 290) v = -16'sd7;
            else if (i == 10)         v = -16'sd6;
            else                      v = 16'(100 + (i % 7));
            beat(v, (i == 299));
        end
        show("long300", -7, 14);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== -16'sd7) begin
            failures++;
            $display("FAIL long_min valid=%b min=%0d required 1/-7", bus.out_valid, bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd14) begin
            failures++;
            $display("FAIL long_idx idx=%0d required 14", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        beat(-16'sd20, 1'b0);
        beat(-16'sd30, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_min !== 16'sd0) begin
            failures++;
            $display("FAIL abort_cleared valid=%b ready=%b min=%0d required 0/1/0",
                     bus.out_valid, bus.in_ready, bus.out_min);
        end
        beat(16'sd9, 1'b0);
        beat(16'sd4, 1'b1);
        show("after_abort", 4, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== 16'sd4) begin
            failures++;
            $display("FAIL abort_next_min valid=%b min=%0d required 1/4", bus.out_valid, bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd1) begin
            failures++;
            $display("FAIL abort_next_idx idx=%0d required 1", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        beat(16'sd3, 1'b0);
        beat(16'sd1, 1'b0);
        beat(16'sd2, 1'b1);
        show("b2b_first", 1, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== 16'sd1) begin
            failures++;
            $display("FAIL b2b_first_min valid=%b min=%0d required 1/1", bus.out_valid, bus.out_min);
        end
        // Next frame is offered immediately; it must wait out exactly the HOLD cycle.
        cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = -16'sd1;
        while (bus.in_ready !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 1) begin
            failures++;
            $display("FAIL b2b_hold_cycles cycles=%0d required 1", cyc);
        end
        beat(-16'sd1, 1'b0);
        beat(-16'sd2, 1'b1);
        show("b2b_second", -2, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== -16'sd2) begin
            failures++;
            $display("FAIL b2b_second_min valid=%b min=%0d required 1/-2", bus.out_valid, bus.out_min);
        end
`ifdef MIN_INT16_STREAM_IDX_EN
        checks++;
        if (bus.out_idx !== 8'd1) begin
            failures++;
            $display("FAIL b2b_second_idx idx=%0d required 1", bus.out_idx);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        checks        = 0;
        failures      = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        test_reset();
        test_basic_frame();
        test_single_beat();
        test_backpressure();
        test_sign_order();
        test_stall();
        test_long_wrap();
        test_abort();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/min_int16_stream.md
MIN_INT16_STREAM -- requirements
Module: min_int16_stream

Interface
REQ-001 Parameter WIDTH, default 16: element width in bits; elements are two's-complement signed.
REQ-002 Parameter IMPL_TYPE, default 1: comparator implementation select, passed unchanged to the comparator sub-module.
REQ-003 Parameter IDX_W, default 8: width of the element index counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_data and in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts an input beat this cycle.
REQ-008 in_data  input  WIDTH  signed element.
REQ-009 in_last  input  1  marks the final element of a frame.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_min  output  WIDTH  signed minimum of the frame.
REQ-013 out_idx  output  IDX_W  frame position of the minimum (0-based); present only per REQ-030.

Function
REQ-014 A beat is accepted iff in_valid && in_ready on a rising edge.
REQ-015 FSM states: IDLE, ACCUM, HOLD.
REQ-016 IDLE: in_ready=1, out_valid=0. An accepted beat loads min_reg=in_data, idx_reg=0, cnt=1. The next state is HOLD if in_last=1, else ACCUM.
REQ-017 ACCUM: in_ready=1, out_valid=0. On an accepted beat, if in_data < min_reg (signed, strict), then min_reg=in_data and idx_reg=cnt. cnt increments. The next state is HOLD if in_last=1, else the block stays in ACCUM.
REQ-018 Ties keep the earlier element: equal values never update min_reg or idx_reg.
REQ-019 HOLD: in_ready=0, out_valid=1. out_min and out_idx hold stable until out_valid && out_ready, after which the block moves to IDLE on the next cycle.
REQ-020 Latency: out_valid asserts the cycle after the in_last beat is accepted. In HOLD with out_ready=1, throughput is one frame per (N+1) cycles, where N is the number of elements in the frame.
REQ-021 cnt and idx_reg wrap modulo 2^IDX_W. Frames longer than 2^IDX_W are legal, and out_idx reports the wrapped position.
REQ-022 in_valid=0 in ACCUM stalls the block with no state change; there is no timeout.
REQ-023 Signed extremes are compared correctly: -32768 < 32767, and -1 < 0.
REQ-024 out_min and out_idx are driven directly from registers; there is no combinational path from in_data to the outputs.

Reset
REQ-025 When rst_n=0 at a rising edge, the block enters IDLE and clears min_reg, idx_reg and cnt to 0.
REQ-026 While in reset and on the cycle after: out_valid=0, out_min=0, out_idx=0, in_ready=1.
REQ-027 Reset asserted mid-frame or in HOLD discards the partial or pending result without emitting it.

Configuration
REQ-028 Macro MIN_INT16_STREAM_IDX_EN controls whether index tracking is compiled in.
REQ-029 Without the macro, the block has no out_idx port, no idx_reg and no cnt, and all other behaviour is identical.
REQ-030 With the macro defined, out_idx, idx_reg and cnt exist and behave per REQ-016 to REQ-021.

Structure
REQ-031 Shared package min_int16_stream_pkg holds the FSM state encodings (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and default constants WIDTH_DEF=16 and IDX_W_DEF=8.
REQ-032 The signed less-than comparison is a single sub-module, lt_int_nbit (params WIDTH and IMPL_TYPE; ports A, B, Y = A<B signed). It is instantiated once, with A=in_data and B=min_reg.

Verification
REQ-033 Frame {5, -3, 7, -3 (last)}, out_ready=1: out_min=-3, out_idx=1, out_valid one cycle after the last beat.
REQ-034 Single-beat frame {-32768, last}: HOLD is entered directly, with out_min=-32768 and out_idx=0.
REQ-035 Frame {0, 32767, -1 (last)} with out_ready held 0 for 5 cycles: out_valid stays 1, out_min=-1 is stable, in_ready=0 throughout, and the result is released on the cycle out_ready=1.
REQ-036 Frame of 300 beats with the minimum -7 at position 270: out_idx=14 (270 mod 256), out_min=-7.
REQ-037 rst_n pulsed low after 2 beats of a frame, then frame {9, 4 (last)}: no result from the aborted frame; the next result is out_min=4, out_idx=1.
REQ-038 Build without MIN_INT16_STREAM_IDX_EN, frame {3, 1, 2 (last)}: out_min=1, and the out_idx port is absent.
